// File: rtl/updown_occupancy_counter.sv
// updown_occupancy_counter: bounded up/down occupancy counter with load, wrap/saturate, level flags and violation alarm
module updown_occupancy_counter #(
    parameter int WIDTH     = 3,
    parameter int MAX_COUNT = 7,
    parameter int WRAP      = 0,
    parameter int AF_LEVEL  = 6,
    parameter int AE_LEVEL  = 1,
    parameter int ERR_W     = 4
) (
    input  logic             clkup,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             alarm_clr,
    output logic [WIDTH-1:0] pcount,
    output logic             full_flag,
    output logic             empty_flag,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             ovf,
    output logic             udf,
    output logic             alarm,
    output logic [ERR_W-1:0] err_cnt
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
    localparam bit WRAP_EN = WRAP != 0;
    logic [WIDTH-1:0] count_q, count_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic ovf_q, ovf_d, udf_q, udf_d, alarm_q, alarm_d;
    logic at_max, at_zero, load_ok, up, dn, viol;
    always_comb begin
        at_max  = count_q == MAX_V;
        at_zero = count_q == '0;
        load_ok = load_val <= MAX_V;
        up      = !load && inc && !dec;
        dn      = !load && dec && !inc;
        // bound checks precede the +/-1, so the result never binary-wraps past MAX_COUNT
        count_d = load ? (load_ok ? load_val : MAX_V)
                : up   ? (at_max ? (WRAP_EN ? '0 : MAX_V) : count_q + 1'b1)
                : dn   ? (at_zero ? (WRAP_EN ? MAX_V : '0) : count_q - 1'b1)
                : count_q;
        ovf_d   = (load && !load_ok) || (up && at_max);
        udf_d   = dn && at_zero;
        viol    = (load && !load_ok) || (!WRAP_EN && ((up && at_max) || (dn && at_zero)));
        alarm_d = viol || (alarm_q && !alarm_clr);
        err_d   = (viol && err_q != '1) ? err_q + 1'b1 : err_q;
    end
    always_ff @(posedge clkup or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            err_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            alarm_q <= alarm_d;
        end
    end
    assign pcount       = count_q;
    assign full_flag    = at_max;
    assign empty_flag   = at_zero;
    assign almost_full  = 32'(count_q) >= AF_LEVEL;
    assign almost_empty = 32'(count_q) <= AE_LEVEL;
    assign ovf          = ovf_q;
    assign udf          = udf_q;
    assign alarm        = alarm_q;
    assign err_cnt      = err_q;
endmodule
